// File: rtl/aes_round_ctrl.sv
// Sequencing FSM for the AES-128 round datapath and key scheduler.
// Defining AES_CTRL_ABORT_EN adds an abort input that drops the in-flight block.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned ROUND_W    = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef AES_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               key_load,
    output logic               key_en,
    output logic               rcon_clr,
    output logic               state_load,
    output logic [ROUND_W-1:0] round_idx,
    output logic               last_round,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_cnt
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // State, round counter and completed-block counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            round_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                round_d = ROUND_W'(1);
            end
            S_ROUND: begin
                if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
                    state_d = S_FINAL;
                    round_d = '0;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = in_valid ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
`ifdef AES_CTRL_ABORT_EN
        // Abort only cancels a block still in the key/round pipeline.
        if (abort && (state_q inside {S_LOAD, S_ROUND, S_FINAL})) begin
            state_d = S_IDLE;
            round_d = '0;
        end
`endif
    end

    // Moore decode; in_ready in DONE follows out_ready for back-to-back blocks.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        key_load   = 1'b0;
        key_en     = 1'b0;
        rcon_clr   = 1'b0;
        state_load = 1'b0;
        round_idx  = '0;
        last_round = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_LOAD: begin
                key_load   = 1'b1;
                rcon_clr   = 1'b1;
                state_load = 1'b1;
            end
            S_ROUND: begin
                key_en    = 1'b1;
                round_idx = round_q;
            end
            S_FINAL: begin
                key_en     = 1'b1;
                round_idx  = ROUND_W'(NUM_ROUNDS);
                last_round = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: cycle tables, block scoreboard and corner sequences.
// A second instance (NUM_ROUNDS=2, CNT_W=2) covers the short-round and counter-wrap cases.
module tb_aes_round_ctrl;

    localparam int unsigned NR  = 10;
    localparam int unsigned RW  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned NR2 = 2;
    localparam int unsigned CW2 = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid, out_ready;
    logic          in_ready, out_valid, key_load, key_en, rcon_clr, state_load;
    logic [RW-1:0] round_idx;
    logic          last_round, busy;
    logic [CW-1:0] blk_cnt;
`ifdef AES_CTRL_ABORT_EN
    logic          abort;
`endif

    logic           in_valid2, out_ready2;
    logic           in_ready2, out_valid2, key_load2, key_en2, rcon_clr2, state_load2;
    logic [RW-1:0]  round_idx2;
    logic           last_round2, busy2;
    logic [CW2-1:0] blk_cnt2;

    always #5 CLK = ~CLK;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(RW), .CNT_W(CW)) u_dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .key_load(key_load), .key_en(key_en), .rcon_clr(rcon_clr),
        .state_load(state_load), .round_idx(round_idx), .last_round(last_round),
        .busy(busy), .blk_cnt(blk_cnt)
    );

    aes_round_ctrl #(.NUM_ROUNDS(NR2), .ROUND_W(RW), .CNT_W(CW2)) u_dut2 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2),
`ifdef AES_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .key_load(key_load2), .key_en(key_en2), .rcon_clr(rcon_clr2),
        .state_load(state_load2), .round_idx(round_idx2), .last_round(last_round2),
        .busy(busy2), .blk_cnt(blk_cnt2)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [13:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int exp_cnt = 0;
    int exp_q[$];
    int load_cyc = 0;
    int ken_cnt  = 0;
    int overlap  = 0;
    bit hs_pend  = 0;
    bit ov_prev  = 0;

    vec_t tab1[14];
    vec_t tab2[22];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [13:0] pk(input logic ir, ov, kl, ke, rc, sl, lr, bz,
                                       input logic [3:0] ri, input logic [1:0] c);
        return {ir, ov, kl, ke, rc, sl, lr, bz, ri, c};
    endfunction

    function automatic vec_t mk(input logic iv, ordy, ir, ov, kl, ke, rc, sl, lr, bz,
                                input int ri, input int c);
        vec_t v;
        v.iv   = iv;
        v.ordy = ordy;
        v.exp  = pk(ir, ov, kl, ke, rc, sl, lr, bz, 4'(ri), 2'(c));
        return v;
    endfunction

    function automatic logic [13:0] act1();
        return pk(in_ready, out_valid, key_load, key_en, rcon_clr, state_load,
                  last_round, busy, round_idx, blk_cnt[1:0]);
    endfunction

    function automatic logic [13:0] act2();
        return pk(in_ready2, out_valid2, key_load2, key_en2, rcon_clr2, state_load2,
                  last_round2, busy2, round_idx2, blk_cnt2);
    endfunction

    // One cycle: sample at the falling edge and run the block scoreboard on the main DUT.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (!RST) begin
            hs_pend = 0; ov_prev = 0; ken_cnt = 0; overlap = 0;
        end else begin
            if (hs_pend) begin
                if (exp_q.size() == 0) chk("unexpected_completion", int'(blk_cnt), -1);
                else chk("blk_cnt", int'(blk_cnt), exp_q.pop_front());
            end
            if (state_load) begin
                load_cyc = cyc; ken_cnt = 0; overlap = 0;
                chk("load_strobes", int'({key_load, rcon_clr}), 3);
            end
            if (key_en) ken_cnt++;
            if (key_en && key_load) overlap++;
            if (out_valid && !ov_prev) begin
                chk("latency", cyc - load_cyc, NR + 1);
                chk("key_en_cycles", ken_cnt, NR);
                chk("key_load_key_en_overlap", overlap, 0);
            end
            hs_pend = out_valid && out_ready;
            ov_prev = out_valid;
        end
    endtask

    task automatic push_block();
        exp_cnt = (exp_cnt + 1) % 256;
        exp_q.push_back(exp_cnt);
    endtask

    task automatic wait_load(input string nm);
        int n = 0;
        while (!state_load && n < 20) begin tick(); n++; end
        chk(nm, int'(state_load), 1);
    endtask

    task automatic wait_round(input string nm, input int r);
        int n = 0;
        while (int'(round_idx) != r && n < 20) begin tick(); n++; end
        chk(nm, int'(round_idx), r);
    endtask

    task automatic wait_ov(input string nm);
        int n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        chk(nm, int'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads, idles, prev_load;

        RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif

        // Single block trace.
        tab1[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab1[1]  = mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        for (int r = 1; r < int'(NR); r++)
            tab1[1 + r] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, r, 0);
        tab1[11] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 1, NR, 0);
        tab1[12] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tab1[13] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // NUM_ROUNDS=2, CNT_W=2 instance: five back-to-back blocks.
        tab2[0] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            case ((k - 1) % 4)
                0: tab2[k] = mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, ((k - 1) / 4) % 4);
                1: tab2[k] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, ((k - 1) / 4) % 4);
                2: tab2[k] = mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 1, NR2, ((k - 1) / 4) % 4);
                default: tab2[k] = mk(k != 20, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, ((k - 1) / 4) % 4);
            endcase
        end
        tab2[21] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) tick();
        chk("reset_outputs", int'(act1()), int'(pk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0)));
        chk("reset_blk_cnt", int'(blk_cnt), 0);
        RST = 1'b1;

        push_block();
        for (int k = 0; k < 14; k++) begin
            tick();
            chk($sformatf("single[%0d]", k), int'(act1()), int'(tab1[k].exp));
            in_valid  = tab1[k].iv;
            out_ready = tab1[k].ordy;
        end

        // Three blocks back to back with in_valid and out_ready held high.
        push_block(); push_block(); push_block();
        in_valid = 1'b1; loads = 0; idles = 0; prev_load = -1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (state_load) begin
                if (prev_load >= 0) chk("b2b_spacing", cyc - prev_load, NR + 2);
                prev_load = cyc;
                loads++;
            end
            if (!busy) idles++;
            if (k == 36) in_valid = 1'b0;
        end
        chk("b2b_loads", loads, 3);
        chk("b2b_idle_cycles", idles, 0);
        tick();
        chk("b2b_blk_cnt", int'(blk_cnt), 4);
        chk("b2b_back_to_idle", int'(busy), 0);

        // Downstream stall in DONE.
        push_block();
        out_ready = 1'b0; in_valid = 1'b1;
        wait_load("stall_load");
        in_valid = 1'b0;
        wait_ov("stall_out_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk($sformatf("stall[%0d]", i), int'({out_valid, in_ready, key_en, key_load}), 8);
            chk($sformatf("stall_cnt[%0d]", i), int'(blk_cnt), 4);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release", int'({out_valid, busy}), 0);
        chk("stall_blk_cnt", int'(blk_cnt), 5);

        // Asynchronous reset in the middle of round 5.
        in_valid = 1'b1;
        wait_load("rst_load");
        in_valid = 1'b0;
        wait_round("rst_round5", 5);
        #2 RST = 1'b0;
        #1;
        chk("async_reset_outputs", int'(act1()), int'(pk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0)));
        chk("async_reset_blk_cnt", int'(blk_cnt), 0);
        tick(); tick();
        exp_q.delete();
        exp_cnt = 0;
        RST = 1'b1;
        push_block();
        in_valid = 1'b1;
        wait_load("post_rst_load");
        in_valid = 1'b0;
        for (int r = 1; r < int'(NR); r++) begin
            tick();
            chk($sformatf("post_rst_round[%0d]", r), int'(round_idx), r);
        end
        wait_ov("post_rst_out_valid");
        tick();
        chk("post_rst_blk_cnt", int'(blk_cnt), 1);

`ifdef AES_CTRL_ABORT_EN
        // Abort at round 4, then a clean block.
        in_valid = 1'b1;
        wait_load("abort_load");
        in_valid = 1'b0;
        wait_round("abort_round4", 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", int'(act1()), int'(pk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 2'd1)));
        idles = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid || busy) idles++;
        end
        chk("abort_no_output", idles, 0);
        chk("abort_blk_cnt", int'(blk_cnt), 1);
        push_block();
        in_valid = 1'b1;
        wait_load("after_abort_load");
        in_valid = 1'b0;
        wait_ov("after_abort_out_valid");
        tick();
        chk("after_abort_blk_cnt", int'(blk_cnt), 2);
`endif
        chk("scoreboard_drained", exp_q.size(), 0);

        for (int k = 0; k < 22; k++) begin
            tick();
            chk($sformatf("short_wrap[%0d]", k), int'(act2()), int'(tab2[k].exp));
            in_valid2  = tab2[k].iv;
            out_ready2 = tab2[k].ordy;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
